// File: rtl/tff_sched_pkg.sv
// ============================================================================
// Module  : tff_sched_pkg
// Brief   : Shared state encoding and parameter defaults for tff_count_sched.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tff_sched_pkg;

    localparam int DEF_W        = 4;
    localparam int DEF_PRESCALE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tff_cell.sv
// ============================================================================
// Module  : tff_cell
// Brief   : Single T flip-flop with synchronous active-high reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tff_count_sched.sv
// ============================================================================
// Module  : tff_count_sched
// Brief   : Start/stop/one-shot sequencer driving a bank of T cells as a
//           programmable modulo counter. Optional tick prescaler is enabled
//           by defining TFF_SCHED_PRESCALE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_count_sched
    import tff_sched_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         oneshot,
    input  logic         dir,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         tc,
    output logic         done
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_limit;
    logic         r_dir;
    logic         r_oneshot;
    logic         r_tc;

    logic [W-1:0] w_t;
    logic [W-1:0] w_next;
    logic         w_terminal;
    logic         w_tick;
    logic         w_tc_nxt;
    logic         w_accept;

    assign w_accept = (r_state == IDLE) && start && !stop;

`ifdef TFF_SCHED_PRESCALE_EN
    localparam int              c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);

    logic [c_PW-1:0] r_pre;

    assign w_tick = (r_pre == c_PRE_LAST);

    // Held at zero outside RUN, so every run starts a fresh prescale period.
    always_ff @(posedge clk) begin
        if (reset || (r_state != RUN) || stop || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end
`else
    localparam int c_unused_prescale = PRESCALE;

    assign w_tick = 1'b1;
`endif

    always_comb begin
        if (r_dir) begin
            w_terminal = (count == r_limit);
            w_next     = w_terminal ? {W{1'b0}} : count + 1'b1;
        end else begin
            w_terminal = (count == {W{1'b0}});
            w_next     = w_terminal ? r_limit : count - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t         = {W{1'b0}};
        w_tc_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                    w_t         = count ^ (dir ? {W{1'b0}} : limit);
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    w_tc_nxt = w_terminal;
                    // A one-shot run freezes on its terminal value instead of wrapping.
                    if (w_terminal && r_oneshot) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_t = count ^ w_next;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_tc      <= 1'b0;
            r_limit   <= {W{1'b0}};
            r_dir     <= 1'b0;
            r_oneshot <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tc    <= w_tc_nxt;
            if (w_accept) begin
                r_limit   <= limit;
                r_dir     <= dir;
                r_oneshot <= oneshot;
            end
        end
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (w_t[gi]),
            .q     (count[gi])
        );
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign tc   = r_tc;

endmodule

`default_nettype wire
